egg_countdown: RTL
==================

# egg_countdown

Countdown core of the egg timer, directly downstream of the button debouncers. It consumes the debounced start and increment button levels, converts them to single-cycle press events, and holds a BCD minutes:seconds preset. It counts that preset down on a 1 Hz enable and raises an alarm at 00:00. Its outputs drive the display mux and the buzzer.

## Interface
- ALARM_SECONDS, 30: ticks the alarm stays asserted before auto-return to IDLE; legal range 1..255.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- tick_1hz  input  1  single-cycle enable pulse, once per second, synchronous to clk.
- btn_start  input  1  debounced level, start/pause/acknowledge.
- btn_min  input  1  debounced level, increment minutes.
- btn_sec  input  1  debounced level, increment seconds.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD time digits.
- state  output  2  registered FSM state: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- alarm  output  1  registered; high only in ALARM.

## Operation
- Press detection: one prev register per button, reset to 0. A press is level & ~prev and lasts exactly one cycle. A level that is already high when reset is released produces one press in the first cycle after release. Holding a button never repeats the press.
- IDLE:
  - start press with time ≠ 00:00 -> RUN. With time = 00:00 the press is ignored.
  - min press: minutes +1 in BCD, 99 wraps to 00.
  - sec press: seconds +1 in BCD, 59 wraps to 00. Seconds never carry into minutes.
  - min and sec presses in the same cycle: both apply.
  - start has priority: a start press that coincides with min/sec presses discards the increments, even if the start itself is ignored because time = 00:00.
- RUN:
  - tick: time −1 in BCD. Borrow chain: sec_ones 0->9, sec_tens 0->5, min_ones 0->9, min_tens 0->9.
  - A decrement that reaches 00:00 -> ALARM.
  - start press -> PAUSE.
  - min/sec presses are ignored.
- PAUSE:
  - time is frozen and ticks are ignored.
  - start press -> RUN.
  - min or sec press -> IDLE with time retained; that press does not increment.
  - start has priority over min/sec presses in the same cycle.
- ALARM:
  - time holds 00:00 and alarm = 1.
  - A counter clears on entry and counts ticks.
  - Any button press -> IDLE and alarm clears.
  - On the ALARM_SECONDS-th tick -> IDLE automatically.
  - Time stays 00:00 on exit.
- Alarm counter width is $clog2(ALARM_SECONDS+1) bits and it saturates at ALARM_SECONDS.
- Digit registers only ever hold legal BCD: tens of seconds 0..5, all others 0..9.

## Timing
- Reset values: all digits 0, state = IDLE (0), alarm = 0, prev registers 0, alarm counter 0.
- Reset asserted mid-RUN or mid-ALARM returns everything to the reset values immediately, without waiting for a clock edge.
- Button latency: the cycle in which a level first rises is the press cycle. Digits and state update on the next posedge, so they are visible 1 clk after the level rises.
- Tick latency: if tick_1hz is high at posedge N, the decremented time is visible after edge N.
- RUN, tick coincides with start press in the same cycle:
  - the decrement applies and state -> PAUSE;
  - if the decrement reaches 00:00, ALARM wins over PAUSE.
- Entering RUN from IDLE/PAUSE in the same cycle as a tick: that tick is not counted. The first decrement is on the next tick.
- ALARM, tick coincides with a button press in the same cycle: the press takes effect -> IDLE (same visible result as the timeout).
- alarm rises on the same edge at which the digits show 00:00 and falls on the same edge at which state leaves ALARM.

## Test plan
- Reset, then 3 btn_min presses, 45 btn_sec presses, start press -> time 03:45, state 1. After 1 tick 03:44. After 225 ticks total, time 00:00, state 3, alarm 1.
- IDLE at 00:59, 1 btn_sec press -> 00:00 with minutes unchanged. From 99:00, 1 btn_min press -> 00:00. Start press at 00:00 -> state stays 0.
- RUN at 01:00, 1 tick -> 00:59 (full borrow chain). RUN at 10:00, 1 tick -> 09:59.
- RUN at 00:01, tick and start press in the same cycle -> 00:00, state 3, not PAUSE. RUN at 00:05, tick and start together -> 00:04, state 2. Then btn_min press -> state 0, time 00:04 unchanged.
- ALARM with ALARM_SECONDS = 3: no presses, 3 ticks -> state 0, alarm 0 after the 3rd tick. Repeat with a btn_sec press after 1 tick -> state 0 and time stays 00:00.
- btn_min held high for 1000 cycles -> exactly 1 increment.
- btn_start held high through reset release -> exactly one press in the first cycle after release. With time = 00:00 that press is ignored and state stays 0.
- reset pulsed mid-RUN with no clk edge -> all outputs 0 during the pulse.

Source files
------------

// File: rtl/egg_countdown.sv
// egg_countdown: BCD mm:ss egg-timer countdown with press detection, pause and self-clearing alarm.
module egg_countdown #(
    parameter int ALARM_SECONDS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       alarm
);
    localparam int CW = $clog2(ALARM_SECONDS + 1);
    localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_SECONDS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        cur, nxt;
    logic          prev_start, prev_min, prev_sec;
    logic          press_start, press_min, press_sec;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]    mt_n, mo_n, st_n, so_n;
    logic [3:0]    dmt, dmo, dst, dso, imt, imo, ist, iso;
    logic          b0, b1, b2, time_zero, dec_zero;

    assign press_start = btn_start & ~prev_start;
    assign press_min   = btn_min & ~prev_min;
    assign press_sec   = btn_sec & ~prev_sec;

    // borrow chain for the one-second decrement
    assign b0  = sec_ones == 4'd0;
    assign b1  = b0 && sec_tens == 4'd0;
    assign b2  = b1 && min_ones == 4'd0;
    assign dso = b0 ? 4'd9 : sec_ones - 4'd1;
    assign dst = b0 ? (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1) : sec_tens;
    assign dmo = b1 ? (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1) : min_ones;
    assign dmt = b2 ? (min_tens == 4'd0 ? 4'd9 : min_tens - 4'd1) : min_tens;

    assign imo = min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1;
    assign imt = min_ones == 4'd9 ? (min_tens == 4'd9 ? 4'd0 : min_tens + 4'd1) : min_tens;
    assign iso = sec_ones == 4'd9 ? 4'd0 : sec_ones + 4'd1;
    assign ist = sec_ones == 4'd9 ? (sec_tens == 4'd5 ? 4'd0 : sec_tens + 4'd1) : sec_tens;

    assign time_zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0;
    assign dec_zero  = {dmt, dmo, dst, dso} == 16'h0;
    assign cnt_inc   = cnt == ALARM_LAST ? cnt : cnt + 1'b1;
    assign state     = cur;

    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        {mt_n, mo_n, st_n, so_n} = {min_tens, min_ones, sec_tens, sec_ones};
        case (cur)
            IDLE: begin
                if (press_start) nxt = time_zero ? IDLE : RUN;
                else begin
                    if (press_min) {mt_n, mo_n} = {imt, imo};
                    if (press_sec) {st_n, so_n} = {ist, iso};
                end
            end
            RUN: begin
                if (tick_1hz) {mt_n, mo_n, st_n, so_n} = {dmt, dmo, dst, dso};
                if (tick_1hz && dec_zero) begin
                    nxt     = ALARM;
                    cnt_nxt = '0;
                end else if (press_start) nxt = PAUSE;
            end
            PAUSE: begin
                if (press_start) nxt = RUN;
                else if (press_min || press_sec) nxt = IDLE;
            end
            ALARM: begin
                if (press_start || press_min || press_sec) nxt = IDLE;
                else if (tick_1hz) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == ALARM_LAST) nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            alarm      <= 1'b0;
            cnt        <= '0;
            prev_start <= 1'b0;
            prev_min   <= 1'b0;
            prev_sec   <= 1'b0;
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0;
        end else begin
            cur        <= nxt;
            alarm      <= nxt == ALARM;
            cnt        <= cnt_nxt;
            prev_start <= btn_start;
            prev_min   <= btn_min;
            prev_sec   <= btn_sec;
            {min_tens, min_ones, sec_tens, sec_ones} <= {mt_n, mo_n, st_n, so_n};
        end
    end
endmodule
